gate_bist_checker: RTL and testbench

Hardware self-test engine that drives a 2-input combinational gate. It sweeps the gate's inputs through all four vectors in the order 00, 01, 10, 11. After each vector settles, it samples the gate output and compares it against a parameterised truth table. It sits beside the gate under test and reports per-vector pass/fail, an error count and a done flag.

---
 rtl/gate_bist_pkg.sv | 24 ++
 rtl/gate_bist_if.sv | 37 +++
 rtl/gate_bist_timer.sv | 30 +++
 rtl/gate_bist_checker.sv | 101 ++++++++++
 tb/tb_gate_bist_checker.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the 2-input gate self-test engine.
// Truth tables are indexed by {a,b}, so bit 3 is the expected output for vector 11.
package gate_bist_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;

   localparam int TIMER_W = 8;

   function automatic logic tt_lookup(input logic [3:0] tt, input logic [1:0] idx);
      return tt[idx];
   endfunction

endpackage

// File: rtl/gate_bist_if.sv
// Connection bundle between the self-test engine and its surroundings (gate under test and control).
// The engine owns the gate inputs and the result flags; the other side owns start and the gate output.
interface gate_bist_if;
   logic       start;
   logic       a_out;
   logic       b_out;
   logic       y_in;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] fail_vec;
   logic [2:0] err_count;

   modport master (
      output start,
      output y_in,
      input  a_out,
      input  b_out,
      input  busy,
      input  done,
      input  pass,
      input  fail_vec,
      input  err_count
   );

   modport slave (
      input  start,
      input  y_in,
      output a_out,
      output b_out,
      output busy,
      output done,
      output pass,
      output fail_vec,
      output err_count
   );
endinterface

// File: rtl/gate_bist_timer.sv
// Settle counter: counts while enabled, cleared on demand; expired flags that this count step reaches limit.
// expired is combinational on the registered count so the FSM can move to SAMPLE in the same edge.
module gate_bist_timer
   import gate_bist_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               enable,
   input  logic [TIMER_W-1:0] limit,
   output logic               expired
);

   logic [TIMER_W-1:0] r_count;
   logic [TIMER_W:0]   w_next;

   assign w_next  = {1'b0, r_count} + {{TIMER_W{1'b0}}, 1'b1};
   assign expired = (w_next == {1'b0, limit});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (enable) begin
         r_count <= w_next[TIMER_W-1:0];
      end
   end

endmodule

// File: rtl/gate_bist_checker.sv
// Sweeps a 2-input gate through 00,01,10,11, holding each SETTLE_CYCLES+1 cycles and sampling on the last.
// Sweep takes 4*(SETTLE_CYCLES+1) cycles; start is ignored while busy, results hold until the next start.
module gate_bist_checker
   import gate_bist_pkg::*;
#(
   parameter int         SETTLE_CYCLES = 2,
   parameter logic [3:0] EXPECTED      = TT_AND
) (
   input  logic      clk,
   input  logic      rst_n,
   gate_bist_if.slave bus
);

   localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(SETTLE_CYCLES);
   // With no settle time each vector is sampled in its first cycle, so SETTLE is skipped entirely.
   localparam state_t FIRST_ST = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

   state_t     r_state;
   logic [1:0] r_idx;
   logic [3:0] r_fail_vec;
   logic [2:0] r_err_count;
   logic       r_busy;
   logic       r_done;
   logic       r_pass;

   logic       w_expired;
   logic       w_mismatch;
   logic [3:0] w_fail_upd;

   gate_bist_timer u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (r_state != SETTLE),
      .enable  (r_state == SETTLE),
      .limit   (LIMIT),
      .expired (w_expired)
   );

   assign w_mismatch = bus.y_in ^ tt_lookup(EXPECTED, r_idx);

   always_comb begin
      w_fail_upd        = r_fail_vec;
      w_fail_upd[r_idx] = r_fail_vec[r_idx] | w_mismatch;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_idx       <= 2'd0;
         r_fail_vec  <= 4'd0;
         r_err_count <= 3'd0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (bus.start) begin
                  r_idx       <= 2'd0;
                  r_fail_vec  <= 4'd0;
                  r_err_count <= 3'd0;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
                  r_pass      <= 1'b0;
                  r_state     <= FIRST_ST;
               end
            end
            SETTLE: begin
               if (w_expired) begin
                  r_state <= SAMPLE;
               end
            end
            SAMPLE: begin
               r_fail_vec <= w_fail_upd;
               if (w_mismatch) begin
                  r_err_count <= r_err_count + 3'd1;
               end
               if (r_idx == 2'd3) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= ~|w_fail_upd;
               end else begin
                  r_idx   <= r_idx + 2'd1;
                  r_state <= FIRST_ST;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.a_out     = r_idx[1];
   assign bus.b_out     = r_idx[0];
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.pass      = r_pass;
   assign bus.fail_vec  = r_fail_vec;
   assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_gate_bist_checker.sv
// Scoreboard bench: issued sweeps push expected vectors and results; per-DUT monitors pop and compare.
// dut0 checks an AND table with 2 settle cycles, dut1 an XOR table with no settle time.
module tb_gate_bist_checker;
   import gate_bist_pkg::*;

   typedef struct {
      int         start_cyc;
      int         lat;
      logic       pass;
      logic [3:0] fv;
      logic [2:0] ec;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   mode0 = 0;   // 0 AND, 1 stuck-at-0, 2 NAND, 3 XOR
   int   mode1 = 3;

   exp_t       q_res0[$];
   exp_t       q_res1[$];
   logic [1:0] q_vec0[$];
   logic [1:0] q_vec1[$];
   logic       done0_q = 1'b0;
   logic       done1_q = 1'b0;

   gate_bist_if bus0();
   gate_bist_if bus1();

   gate_bist_checker #(.SETTLE_CYCLES(2), .EXPECTED(TT_AND)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   gate_bist_checker #(.SETTLE_CYCLES(0), .EXPECTED(TT_XOR)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   function automatic logic gate_f(input int m, input logic a, input logic b);
      case (m)
         0:       return a & b;
         1:       return 1'b0;
         2:       return ~(a & b);
         3:       return a ^ b;
         default: return 1'b0;
      endcase
   endfunction

   assign bus0.y_in = gate_f(mode0, bus0.a_out, bus0.b_out);
   assign bus1.y_in = gate_f(mode1, bus1.a_out, bus1.b_out);

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   always @(negedge clk) begin : mon0
      exp_t       e;
      logic [1:0] v;
      if (rst_n) begin
         if (bus0.busy) begin
            if (q_vec0.size() == 0) chk("vec0_extra_busy", 32'(bus0.busy), 32'd0);
            else begin
               v = q_vec0.pop_front();
               chk("vec0_ab", 32'({bus0.a_out, bus0.b_out}), 32'(v));
            end
         end
         if (bus0.done && !done0_q) begin
            if (q_res0.size() == 0) chk("res0_extra_done", 32'(bus0.done), 32'd0);
            else begin
               e = q_res0.pop_front();
               chk("res0_latency", 32'(cyc - e.start_cyc), 32'(e.lat));
               chk("res0_pass", 32'(bus0.pass), 32'(e.pass));
               chk("res0_fail_vec", 32'(bus0.fail_vec), 32'(e.fv));
               chk("res0_err_count", 32'(bus0.err_count), 32'(e.ec));
               chk("res0_busy_low", 32'(bus0.busy), 32'd0);
            end
         end
      end
      done0_q = bus0.done;
   end

   always @(negedge clk) begin : mon1
      exp_t       e;
      logic [1:0] v;
      if (rst_n) begin
         if (bus1.busy) begin
            if (q_vec1.size() == 0) chk("vec1_extra_busy", 32'(bus1.busy), 32'd0);
            else begin
               v = q_vec1.pop_front();
               chk("vec1_ab", 32'({bus1.a_out, bus1.b_out}), 32'(v));
            end
         end
         if (bus1.done && !done1_q) begin
            if (q_res1.size() == 0) chk("res1_extra_done", 32'(bus1.done), 32'd0);
            else begin
               e = q_res1.pop_front();
               chk("res1_latency", 32'(cyc - e.start_cyc), 32'(e.lat));
               chk("res1_pass", 32'(bus1.pass), 32'(e.pass));
               chk("res1_fail_vec", 32'(bus1.fail_vec), 32'(e.fv));
               chk("res1_err_count", 32'(bus1.err_count), 32'(e.ec));
               chk("res1_busy_low", 32'(bus1.busy), 32'd0);
            end
         end
      end
      done1_q = bus1.done;
   end

   // Pulses start for one cycle and records the expected per-cycle vectors and final result.
   task automatic issue(input int d, input logic p, input logic [3:0] fv, input logic [2:0] ec);
      exp_t e;
      int   s;
      @(negedge clk);
      s           = (d == 0) ? 2 : 0;
      e.start_cyc = cyc + 1;
      e.lat       = 4 * (s + 1);
      e.pass      = p;
      e.fv        = fv;
      e.ec        = ec;
      if (d == 0) begin
         bus0.start = 1'b1;
         q_res0.push_back(e);
      end else begin
         bus1.start = 1'b1;
         q_res1.push_back(e);
      end
      for (int v = 0; v < 4; v++) begin
         for (int k = 0; k <= s; k++) begin
            if (d == 0) q_vec0.push_back(2'(v));
            else        q_vec1.push_back(2'(v));
         end
      end
      @(negedge clk);
      bus0.start = 1'b0;
      bus1.start = 1'b0;
   endtask

   task automatic wait_idle(input int d);
      int i;
      int rem;
      i   = 0;
      rem = (d == 0) ? (q_res0.size() + q_vec0.size()) : (q_res1.size() + q_vec1.size());
      while (i < 100 && rem != 0) begin
         @(negedge clk);
         #1;
         i++;
         rem = (d == 0) ? (q_res0.size() + q_vec0.size()) : (q_res1.size() + q_vec1.size());
      end
      chk((d == 0) ? "drain0_pending" : "drain1_pending", 32'(rem), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bool_found_init();
   end

   task automatic bool_found_init();
      int found;
      bus0.start = 1'b0;
      bus1.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_a_out", 32'(bus0.a_out), 32'd0);
      chk("rst_b_out", 32'(bus0.b_out), 32'd0);
      chk("rst_busy", 32'(bus0.busy), 32'd0);
      chk("rst_done", 32'(bus0.done), 32'd0);
      chk("rst_pass", 32'(bus0.pass), 32'd0);
      chk("rst_fail_vec", 32'(bus0.fail_vec), 32'd0);
      chk("rst_err_count", 32'(bus0.err_count), 32'd0);
      chk("rst1_busy", 32'(bus1.busy), 32'd0);
      rst_n = 1'b1;

      mode0 = 0;
      issue(0, 1'b1, 4'b0000, 3'd0);
      wait_idle(0);

      mode0 = 1;
      issue(0, 1'b0, 4'b1000, 3'd1);
      wait_idle(0);

      mode0 = 2;
      issue(0, 1'b0, 4'b1111, 3'd4);
      wait_idle(0);
      chk("nand_done_hold", 32'(bus0.done), 32'd1);

      // Restart from DONE clears results; a start mid-sweep must not disturb timing.
      mode0 = 0;
      issue(0, 1'b1, 4'b0000, 3'd0);
      #1;
      chk("restart_busy", 32'(bus0.busy), 32'd1);
      chk("restart_done", 32'(bus0.done), 32'd0);
      chk("restart_fail_vec", 32'(bus0.fail_vec), 32'd0);
      chk("restart_err_count", 32'(bus0.err_count), 32'd0);
      repeat (4) @(negedge clk);
      bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      wait_idle(0);

      // Asynchronous reset while vector 10 is applied.
      issue(0, 1'b1, 4'b0000, 3'd0);
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         if (bus0.a_out && !bus0.b_out) found = 1;
         else @(negedge clk);
      end
      chk("reach_idx2", 32'(found), 32'd1);
      #1;
      rst_n = 1'b0;
      q_res0.delete();
      q_vec0.delete();
      #1;
      chk("midrst_a_out", 32'(bus0.a_out), 32'd0);
      chk("midrst_b_out", 32'(bus0.b_out), 32'd0);
      chk("midrst_busy", 32'(bus0.busy), 32'd0);
      chk("midrst_done", 32'(bus0.done), 32'd0);
      chk("midrst_pass", 32'(bus0.pass), 32'd0);
      chk("midrst_fail_vec", 32'(bus0.fail_vec), 32'd0);
      chk("midrst_err_count", 32'(bus0.err_count), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      issue(0, 1'b1, 4'b0000, 3'd0);
      wait_idle(0);

      mode1 = 3;
      issue(1, 1'b1, 4'b0000, 3'd0);
      wait_idle(1);

      mode1 = 0;
      issue(1, 1'b0, 4'b1110, 3'd3);
      wait_idle(1);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   endtask

endmodule
